// File: rtl/keypad_scan_if.sv
// keypad_scan_if: turn-count handshake between the keypad scanner
// and the downstream relay/turn stage.
interface keypad_scan_if;
  logic [3:0] numgiro_out;
  logic       numgiro_valid_out;
  logic       ack_in;

  modport master (
    output numgiro_out,
    output numgiro_valid_out,
    input  ack_in
  );

  modport slave (
    input  numgiro_out,
    input  numgiro_valid_out,
    output ack_in
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 3x3 matrix keypad scanner with row synchroniser,
// debounce, valid/ack handshake and release wait.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [2:0] linha_in,
  output logic [2:0] coluna_out,
  input  logic       enable_in,
  keypad_scan_if.master hs
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    cand_q, cand_d;
  logic [CW-1:0] deb_q, deb_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [PW-1:0] presc_q;
  logic [2:0]    rows_m, rows_s;
  logic [3:0]    num_q, num_d;
  logic          valid_q, valid_d;
  logic [2:0]    col_out_q, col_out_d;

  logic          tick;
  logic          single;
  logic          none;
  logic [1:0]    row;
  logic [3:0]    code;
  logic [CW-1:0] deb_inc;
  logic [CW-1:0] rel_inc;

  assign tick    = (presc_q == P_LAST);
  assign deb_inc = deb_q + CW'(1);
  assign rel_inc = rel_q + CW'(1);
  assign code    = 4'(row) * 4'd3 + 4'(col_q) + 4'd1;

  // two or more low rows is ghosting and counts as no key
  always_comb begin
    single = 1'b0;
    none   = (rows_s == 3'b111);
    row    = 2'd0;
    unique case (1'b1)
      (rows_s == 3'b110): begin single = 1'b1; row = 2'd0; end
      (rows_s == 3'b101): begin single = 1'b1; row = 2'd1; end
      (rows_s == 3'b011): begin single = 1'b1; row = 2'd2; end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      cand_q    <= 2'd0;
      deb_q     <= '0;
      rel_q     <= '0;
      presc_q   <= '0;
      rows_m    <= 3'b111;
      rows_s    <= 3'b111;
      num_q     <= 4'd0;
      valid_q   <= 1'b0;
      col_out_q <= 3'b110;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      rel_q     <= rel_d;
      presc_q   <= tick ? '0 : presc_q + PW'(1);
      rows_m    <= linha_in;
      rows_s    <= rows_m;
      num_q     <= num_d;
      valid_q   <= valid_d;
      col_out_q <= col_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    rel_d   = rel_q;
    num_d   = num_q;
    unique case (state_q)
      SCAN: begin
        if (tick) begin
          if (enable_in && single) begin
            cand_d = row;
            if (DEBOUNCE_SCANS == 1) begin
              num_d   = code;
              state_d = HOLD;
            end else begin
              deb_d   = CW'(1);
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (!enable_in) begin
          deb_d   = '0;
          state_d = SCAN;
        end else if (tick) begin
          if (single && row == cand_q) begin
            if (deb_inc == D_LAST) begin
              num_d   = code;
              deb_d   = '0;
              state_d = HOLD;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            deb_d   = '0;
            state_d = SCAN;
          end
        end
      end
      HOLD: begin
        if (hs.ack_in) begin
          rel_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (none) begin
            if (rel_inc == D_LAST) begin
              rel_d   = '0;
              col_d   = 2'd0;
              state_d = SCAN;
            end else begin
              rel_d = rel_inc;
            end
          end else begin
            rel_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // outputs are registered from the next-state values
  always_comb begin
    valid_d   = (state_d == HOLD);
    col_out_d = ~(3'b001 << col_d);
    if (state_d == RELEASE) col_out_d = 3'b000;
  end

  assign coluna_out           = col_out_q;
  assign hs.numgiro_out       = num_q;
  assign hs.numgiro_valid_out = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench with a 3x3 switch-matrix model
// driving the rows from the scanned columns.
module tb_keypad_scan;

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic [2:0] linha_in;
  logic [2:0] coluna_out;
  logic       enable_in;
  logic [8:0] keys;

  int errors = 0;
  int checks = 0;

  keypad_scan_if hs();

  keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .linha_in   (linha_in),
    .coluna_out (coluna_out),
    .enable_in  (enable_in),
    .hs         (hs)
  );

  always #5 clock_in = ~clock_in;

  // key (r,c) pulls row r low while column c is driven low
  always_comb begin
    linha_in = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (keys[3*r+c] && !coluna_out[c]) linha_in[r] = 1'b0;
  end

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n, output bit saw);
    saw = 1'b0;
    repeat (n) begin
      step();
      if (hs.numgiro_valid_out !== 1'b0) saw = 1'b1;
    end
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < limit) begin
      step();
      if (hs.numgiro_valid_out === 1'b1) ok = 1'b1;
      i++;
    end
  endtask

  task automatic wait_col(input logic [2:0] v, input int limit,
                          output bit ok);
    int i;
    ok = 1'b0;
    i  = 0;
    while (!ok && i < limit) begin
      step();
      if (coluna_out === v) ok = 1'b1;
      i++;
    end
  endtask

  task automatic do_ack();
    hs.ack_in = 1'b1;
    step();
    hs.ack_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit saw;
    bit bad;

    reset_in  = 1'b0;
    enable_in = 1'b1;
    hs.ack_in = 1'b0;
    keys      = '0;
    step();
    step();
    check("rst_col", 8'(coluna_out), 8'h6);
    check("rst_valid", 8'(hs.numgiro_valid_out), 8'h0);
    check("rst_num", 8'(hs.numgiro_out), 8'h0);
    reset_in = 1'b1;

    // clean press row 1 / column 2
    keys[5] = 1'b1;
    wait_valid(100, ok);
    check("k6_valid", 8'(ok), 8'h1);
    check("k6_num", 8'(hs.numgiro_out), 8'h6);
    do_ack();
    check("k6_ack_valid", 8'(hs.numgiro_valid_out), 8'h0);
    check("k6_rel_col", 8'(coluna_out), 8'h0);
    keys = '0;
    wait_col(3'b110, 100, ok);
    check("k6_back_scan", 8'(ok), 8'h1);
    check("k6_num_hold", 8'(hs.numgiro_out), 8'h6);

    // bounce on row 0 / column 0, ending released
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys[0] = (i % 2 == 0);
      run(4, saw);
      bad |= saw;
    end
    check("bnc_no_valid", 8'(bad), 8'h0);
    keys[0] = 1'b1;
    run(5, saw);
    check("bnc_early", 8'(saw), 8'h0);
    check("bnc_num_old", 8'(hs.numgiro_out), 8'h6);
    wait_valid(100, ok);
    check("bnc_valid", 8'(ok), 8'h1);
    check("bnc_num", 8'(hs.numgiro_out), 8'h1);
    do_ack();
    keys = '0;
    wait_col(3'b110, 100, ok);
    check("bnc_back_scan", 8'(ok), 8'h1);

    // ghost: rows 0 and 2 in column 1
    keys[1] = 1'b1;
    keys[7] = 1'b1;
    run(60, saw);
    check("ghost_none", 8'(saw), 8'h0);
    keys[7] = 1'b0;
    wait_valid(100, ok);
    check("ghost_valid", 8'(ok), 8'h1);
    check("ghost_num", 8'(hs.numgiro_out), 8'h2);
    do_ack();
    keys = '0;
    wait_col(3'b110, 100, ok);
    check("ghost_back", 8'(ok), 8'h1);

    // busy: key 9 held while enable low
    enable_in = 1'b0;
    keys[8]   = 1'b1;
    run(60, saw);
    check("busy_none", 8'(saw), 8'h0);
    enable_in = 1'b1;
    wait_valid(100, ok);
    check("busy_valid", 8'(ok), 8'h1);
    check("busy_num", 8'(hs.numgiro_out), 8'h9);
    do_ack();
    keys = '0;
    wait_col(3'b110, 100, ok);
    check("busy_back", 8'(ok), 8'h1);

    // enable drop mid-debounce on key 3
    keys[2] = 1'b1;
    wait_col(3'b011, 40, ok);
    check("mid_reach_col2", 8'(ok), 8'h1);
    repeat (4) step();
    check("mid_frozen", 8'(coluna_out), 8'h3);
    enable_in = 1'b0;
    run(30, saw);
    check("mid_abort", 8'(saw), 8'h0);
    check("mid_num", 8'(hs.numgiro_out), 8'h9);
    keys      = '0;
    enable_in = 1'b1;
    run(20, saw);
    check("mid_after", 8'(saw), 8'h0);

    // held key with delayed ack
    keys[4] = 1'b1;
    wait_valid(100, ok);
    check("hold_valid", 8'(ok), 8'h1);
    check("hold_num", 8'(hs.numgiro_out), 8'h5);
    bad = 1'b0;
    repeat (100) begin
      step();
      if (hs.numgiro_valid_out !== 1'b1 ||
          hs.numgiro_out !== 4'd5) bad = 1'b1;
    end
    check("hold_stable", 8'(bad), 8'h0);
    do_ack();
    bad = 1'b0;
    repeat (200) begin
      step();
      if (coluna_out !== 3'b000 ||
          hs.numgiro_valid_out !== 1'b0) bad = 1'b1;
    end
    check("hold_release", 8'(bad), 8'h0);
    keys = '0;
    wait_col(3'b110, 100, ok);
    check("hold_back", 8'(ok), 8'h1);

    // asynchronous reset in HOLD with key 4
    keys[3] = 1'b1;
    wait_valid(100, ok);
    check("rh_valid", 8'(ok), 8'h1);
    check("rh_num", 8'(hs.numgiro_out), 8'h4);
    #3;
    reset_in = 1'b0;
    #1;
    check("rh_col", 8'(coluna_out), 8'h6);
    check("rh_vld", 8'(hs.numgiro_valid_out), 8'h0);
    check("rh_n", 8'(hs.numgiro_out), 8'h0);
    keys = '0;
    step();
    reset_in = 1'b1;
    repeat (3) step();
    check("rh_col0", 8'(coluna_out), 8'h6);
    step();
    check("rh_col1", 8'(coluna_out), 8'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
